// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Brief    : Shared letter codes, symbol values and receiver state encoding
//            for the Morse A-H loopback path.
// Revision : 1.0 - initial release
// ============================================================================
package morse_pkg;

    // Letter codes, shared with the display stage's pattern table
    localparam logic [2:0] LETTER_A = 3'd0;
    localparam logic [2:0] LETTER_B = 3'd1;
    localparam logic [2:0] LETTER_C = 3'd2;
    localparam logic [2:0] LETTER_D = 3'd3;
    localparam logic [2:0] LETTER_E = 3'd4;
    localparam logic [2:0] LETTER_F = 3'd5;
    localparam logic [2:0] LETTER_G = 3'd6;
    localparam logic [2:0] LETTER_H = 3'd7;

    // Symbol values as stored in the symbol shift register
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Receiver state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/morse_lookup.sv
`default_nettype none
// ============================================================================
// Module   : morse_lookup
// Brief    : Combinational map from (symbol count, symbol pattern) to a
//            letter code A-H plus a legality flag. First symbol received
//            sits in the most significant of the nsym valid bits.
// Revision : 1.0 - initial release
// ============================================================================
module morse_lookup
    import morse_pkg::*;
(
    input  logic [2:0] nsym,
    input  logic [3:0] sym,
    output logic [2:0] letter,
    output logic       legal
);

    // Unused upper symbol bits are always zero, so the full register is compared
    always_comb begin
        letter = LETTER_A;
        legal  = 1'b1;
        case ({nsym, sym})
            {3'd2, 4'b0001}: letter = LETTER_A;
            {3'd4, 4'b1000}: letter = LETTER_B;
            {3'd4, 4'b1010}: letter = LETTER_C;
            {3'd3, 4'b0100}: letter = LETTER_D;
            {3'd1, 4'b0000}: letter = LETTER_E;
            {3'd4, 4'b0010}: letter = LETTER_F;
            {3'd3, 4'b0110}: letter = LETTER_G;
            {3'd4, 4'b0000}: letter = LETTER_H;
            default:         legal  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_decoder
// Brief    : Tick-sampled Morse receiver. Measures mark/space run lengths,
//            classifies marks as dot/dash, and emits a registered letter
//            code (or an error pulse) once a letter-ending gap is seen.
// Revision : 1.0 - initial release
// ============================================================================
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int DASH_MIN  = 2,
    parameter int MARK_MAX  = 5,
    parameter int GAP_TICKS = 3,
    parameter int CNT_W     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       line,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] RUN_MAX    = '1;
    localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] MARK_MAX_C = CNT_W'(MARK_MAX);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(GAP_TICKS);

    state_t           state;
    logic [CNT_W-1:0] run;
    logic [3:0]       sym;
    logic [2:0]       nsym;
    logic             err_flag;

    logic [CNT_W-1:0] run_inc;
    logic [2:0]       lut_letter;
    logic             lut_legal;

    // Saturating run-length increment; a stuck-high line parks at RUN_MAX
    assign run_inc = (run == RUN_MAX) ? run : run + RUN_ONE;

    morse_lookup u_lookup (
        .nsym   (nsym),
        .sym    (sym),
        .letter (lut_letter),
        .legal  (lut_legal)
    );

    // Receiver FSM with run counter, symbol register and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            run          <= '0;
            sym          <= '0;
            nsym         <= '0;
            err_flag     <= 1'b0;
            letter       <= LETTER_A;
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && line) begin
                        state <= MARK;
                        run   <= RUN_ONE;
                        busy  <= 1'b1;
                    end
                end
                MARK: begin
                    if (tick) begin
                        if (line) begin
                            run <= run_inc;
                        end else begin
                            // Over-long marks poison the letter instead of adding a symbol
                            if (run > MARK_MAX_C) begin
                                err_flag <= 1'b1;
                            end else begin
                                sym <= {sym[2:0], (run >= DASH_MIN_C) ? SYM_DASH : SYM_DOT};
                                if (nsym == 3'd4) begin
                                    err_flag <= 1'b1;
                                end else begin
                                    nsym <= nsym + 3'd1;
                                end
                            end
                            run <= RUN_ONE;
                            // The falling tick already counts as the first space tick
                            if (GAP_TICKS <= 1) begin
                                state <= EMIT;
                                busy  <= 1'b0;
                            end else begin
                                state <= SPACE;
                            end
                        end
                    end
                end
                SPACE: begin
                    if (tick) begin
                        if (line) begin
                            state <= MARK;
                            run   <= RUN_ONE;
                        end else begin
                            run <= run_inc;
                            if (run_inc == GAP_C) begin
                                state <= EMIT;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (lut_legal && !err_flag) begin
                        letter       <= lut_letter;
                        letter_valid <= 1'b1;
                    end else begin
                        letter_err   <= 1'b1;
                    end
                    sym      <= '0;
                    nsym     <= '0;
                    err_flag <= 1'b0;
                    run      <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_rx_decoder
// Brief    : Self-checking bench for morse_rx_decoder. Expected letters are
//            queued as each sequence is driven and popped when a pulse
//            appears on letter_valid / letter_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_rx_decoder;

    typedef struct {
        bit         is_err;
        logic [2:0] letter;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       tick;
    logic       line;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;

    exp_t       sb[$];
    logic [2:0] model_letter;
    int         n_checks;
    int         n_pass;
    int         tick_gap;

    morse_rx_decoder #(
        .DASH_MIN  (2),
        .MARK_MAX  (5),
        .GAP_TICKS (3),
        .CNT_W     (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tick         (tick),
        .line         (line),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected)
            $display("FAIL %s: observed %0d required %0d", tag, observed, expected);
        else
            n_pass++;
    endtask

    // Dot = 1-tick mark, dash = 3-tick mark, 1-tick intra gap, 3-tick letter gap
    function automatic string enc(input string m);
        string s = "";
        for (int i = 0; i < m.len(); i++) begin
            if (i > 0) s = {s, "0"};
            if (m[i] == "-") s = {s, "111"};
            else             s = {s, "1"};
        end
        return {s, "000"};
    endfunction

    // One sample tick; optional tick-low cycles before it carry random line noise
    task automatic tick_line(input logic v, input bit chk_busy);
        @(negedge clock);
        if (chk_busy) check_value("busy_mark", busy, 1);
        for (int g = 0; g < tick_gap; g++) begin
            tick = 1'b0;
            line = 1'($urandom);
            @(negedge clock);
        end
        tick = 1'b1;
        line = v;
    endtask

    task automatic send_seq(input string s, input bit has_exp, input bit is_err,
                            input logic [2:0] ltr);
        exp_t e;
        if (has_exp) begin
            e.is_err = is_err;
            e.letter = ltr;
            sb.push_back(e);
        end
        for (int i = 0; i < s.len(); i++)
            tick_line(s[i] == "1", (i > 0) && (s[i-1] == "1"));
        if (has_exp) begin
            @(negedge clock);
            check_value("pre_emit", {30'd0, letter_valid, letter_err}, 0);
            check_value("busy_emit", busy, 0);
            @(negedge clock);
            check_value("emit_lat", letter_valid | letter_err, 1);
            check_value("busy_after", busy, 0);
            @(negedge clock);
            check_value("pulse_width", letter_valid | letter_err, 0);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n && (letter_valid || letter_err)) begin
            exp_t e;
            check_value("pulse_excl", letter_valid & letter_err, 0);
            if (sb.size() == 0) begin
                check_value("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check_value("kind_err", letter_err, e.is_err);
                if (e.is_err) begin
                    check_value("letter_held", letter, model_letter);
                end else begin
                    check_value("letter", letter, e.letter);
                    model_letter = e.letter;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string morse [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
        n_checks     = 0;
        n_pass       = 0;
        tick_gap     = 0;
        model_letter = 3'd0;
        reset_n      = 1'b0;
        tick         = 1'b0;
        line         = 1'b0;
        repeat (3) @(negedge clock);
        check_value("rst_letter", letter, 0);
        check_value("rst_valid", letter_valid, 0);
        check_value("rst_err", letter_err, 0);
        check_value("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick    = 1'b1;

        // Leading space then A
        send_seq("010111000", 1, 0, 3'd0);

        // All eight letters; two idle ticks keep marks off the EMIT cycle
        for (int k = 0; k < 8; k++) begin
            send_seq(enc(morse[k]), 1, 0, 3'(k));
            tick_line(1'b0, 0);
        end

        // Five dots -> error, letter held
        send_seq("101010101000", 1, 1, 3'd0);
        tick_line(1'b0, 0);

        // Over-long mark -> error, then E shows the flag was cleared
        send_seq("111111000", 1, 1, 3'd0);
        tick_line(1'b0, 0);
        send_seq("1000", 1, 0, 3'd4);
        tick_line(1'b0, 0);

        // Two-tick gap does not split the letter: dash-dot is illegal
        send_seq("111001000", 1, 1, 3'd0);
        tick_line(1'b0, 0);

        // Sparse ticks with line noise between them: C
        tick_gap = 2;
        send_seq(enc("-.-."), 1, 0, 3'd2);
        tick_line(1'b0, 0);
        tick_gap = 0;

        // Mid-letter asynchronous reset discards everything
        send_seq("10111", 0, 0, 3'd0);
        @(negedge clock);
        line    = 1'b0;
        reset_n = 1'b0;
        #1;
        check_value("midrst_busy", busy, 0);
        check_value("midrst_letter", letter, 0);
        model_letter = 3'd0;
        @(negedge clock);
        reset_n = 1'b1;
        tick_line(1'b0, 0);
        check_value("postrst_busy", busy, 0);
        send_seq("1000", 1, 0, 3'd4);
        tick_line(1'b0, 0);
        tick_line(1'b0, 0);

        check_value("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_rx_decoder.md
# morse_rx_decoder

Morse receive decoder for letters A–H: samples a serial on/off line at the half-second tick rate, classifies marks as dots or dashes, and emits a 3-bit letter code when the letter ends. It sits directly downstream of the Morse LED display stage. It takes that stage's LED drive, or an external key line carrying the same timing, and converts it back to the switch code 0–7, closing a loopback test path.

## Interface
- DASH_MIN, 2: mark length in ticks at or above which a mark is a dash; shorter marks are dots.
- MARK_MAX, 5: mark length in ticks above which the mark is illegal.
- GAP_TICKS, 3: consecutive space ticks that terminate a letter.
- CNT_W, 4: run-length counter width; the counter saturates at 2^CNT_W−1.
- clock  in  1  system clock (50 MHz); the block uses the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle sample enable at the symbol rate (one per half second); synchronous to clock.
- line  in  1  serial Morse input, 1 = mark; synchronous to clock.
- letter  out  3  decoded letter: 0 = A … 7 = H. Held until the next emit.
- letter_valid  out  1  one-cycle pulse: `letter` updated with a legal letter.
- letter_err  out  1  one-cycle pulse: the letter just terminated was illegal.
- busy  out  1  high while a letter is being received (state MARK or SPACE).

## Operation
- The block samples `line` only on clock edges where `tick`=1. All other cycles leave state unchanged.
- States:
  - IDLE: on tick with line=1 → MARK, run=1. On line=0, stay.
  - MARK: on tick with line=1, run+1 (saturating). On line=0, classify the mark and shift it into the symbol register; → SPACE, run=1.
  - SPACE: on tick with line=0, run+1. When run reaches GAP_TICKS → EMIT. On line=1 before that, → MARK, run=1.
  - EMIT: one cycle, independent of tick. Pulse `letter_valid` or `letter_err`, clear the symbol register, nsym and the error flag, then → IDLE.
- Mark classification:
  - 1 ≤ run < DASH_MIN: dot (0).
  - DASH_MIN ≤ run ≤ MARK_MAX: dash (1).
  - run > MARK_MAX: sets the sticky error flag.
- Symbol register `sym[3:0]`:
  - Each new symbol shifts in at the LSB, and `nsym` (3 bits) increments.
  - A fifth symbol sets the error flag, and `nsym` saturates at 4.
- Lookup on (nsym, sym):
  - A: n=2, `01`
  - B: n=4, `1000`
  - C: n=4, `1010`
  - D: n=3, `100`
  - E: n=1, `0`
  - F: n=4, `0010`
  - G: n=3, `110`
  - H: n=4, `0000`
  - Any other pattern, or the error flag set, produces `letter_err` instead of `letter_valid`, and `letter` keeps its previous value.
- Leading spaces in IDLE are ignored. A line held at 1 indefinitely stays in MARK with run saturated and emits nothing until the line falls and GAP_TICKS of space follow; the result is then `letter_err`.

## Timing
- Reset values: state IDLE, run=0, sym=0, nsym=0, error flag 0, letter=0, letter_valid=0, letter_err=0, busy=0.
- Reset is asynchronous. Asserting it mid-letter discards all partial symbols, and no pulse is emitted.
- Emit latency: the tick edge that makes the space run reach GAP_TICKS enters EMIT. `letter_valid`/`letter_err` is high in the following cycle, exactly one clock wide. `letter` is updated on the same edge that raises `letter_valid`.
- `tick` arriving during the EMIT cycle is ignored. Stimulus must not present a mark on that tick; at the specified tick rate this cannot occur.
- `busy` is registered: high from the edge that enters MARK until the edge that enters EMIT.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `morse_pkg` holds:
  - letter code constants LETTER_A=3'd0 … LETTER_H=3'd7
  - symbol constants SYM_DOT=1'b0, SYM_DASH=1'b1
  - the state encoding (IDLE, MARK, SPACE, EMIT)
- Sub-module `morse_lookup` is purely combinational. It takes (nsym, sym) and returns letter plus a legal flag. The display stage's pattern table uses the same codes.

## Test plan
Every scenario below holds `tick`=1 every cycle. Each digit in a line sequence is the value of `line` on one tick.
- Line 0 1 0 111 000 → `letter_valid` one cycle after the third trailing 0, with `letter`=0 (A), `busy` low afterwards.
- Sweep all 8 letters with their dot/dash sequences, each followed by 000 → `letter` = 0..7 in order, eight `letter_valid` pulses, no `letter_err`.
- Line 1 0 1 0 1 0 1 0 1 000 (five dots) → `letter_err` pulse only, `letter` unchanged.
- Line 111111 000 (mark longer than MARK_MAX) → `letter_err`. Then 1 000 → `letter_valid` with `letter`=4 (E), showing the error flag cleared.
- Line 111 00 1 000 (gap of only 2 ticks) → a single letter, dash-dot (n=2, `10`) → `letter_err`, not two letters.
- Assert reset_n low for 1 cycle after 1 0 111 → no pulse. A subsequent 1 000 → `letter`=4 (E).
